// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: multi-master / multi-slave shared bus with registered
// round-robin arbitration, per-slave address windows and a registered read
// return select.
//
// Ports:
//   clk, reset_n      bus clock (rising edge), async active-low reset
//   M_req/M_wr        per-master request and write strobe
//   M_addr/M_dout     packed per-master address and write data
//   M_grant           registered one-hot grant
//   M_din             read data broadcast to all masters
//   S_sel             one-hot slave select (address window decode)
//   S_addr/S_wr/S_din bus address, write strobe and write data from the owner
//   S_dout            packed per-slave read data
//
// Build option: define BUS_TIMEOUT_EN to add the MAX_HOLD ownership limit.
// Without it the owner keeps the bus for as long as its request stays high.
module bus_rr_arbiter #(
   parameter int unsigned          NUM_M    = 2,
   parameter int unsigned          NUM_S    = 2,
   parameter int unsigned          AW       = 8,
   parameter int unsigned          DW       = 32,
   parameter logic [NUM_S*AW-1:0]  S_BASE   = {8'h30, 8'h00},
   parameter logic [NUM_S*AW-1:0]  S_MASK   = {8'hF0, 8'hE0},
   parameter int unsigned          MAX_HOLD = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_M-1:0]    M_req,
   input  logic [NUM_M-1:0]    M_wr,
   input  logic [NUM_M*AW-1:0] M_addr,
   input  logic [NUM_M*DW-1:0] M_dout,
   output logic [NUM_M-1:0]    M_grant,
   output logic [DW-1:0]       M_din,
   output logic [NUM_S-1:0]    S_sel,
   output logic [AW-1:0]       S_addr,
   output logic                S_wr,
   output logic [DW-1:0]       S_din,
   input  logic [NUM_S*DW-1:0] S_dout
);

   localparam int unsigned IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   // Elaboration-time parameter sanity
   if (NUM_M < 2 || NUM_M > 8) begin : g_bad_num_m
      $error("bus_rr_arbiter: NUM_M must be 2..8");
   end
   if (NUM_S < 1 || NUM_S > 8) begin : g_bad_num_s
      $error("bus_rr_arbiter: NUM_S must be 1..8");
   end
   if (MAX_HOLD < 1) begin : g_bad_max_hold
      $error("bus_rr_arbiter: MAX_HOLD must be at least 1");
   end

   logic             owner_valid_q, owner_valid_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    last_q, last_d;
   logic [NUM_M-1:0] grant_q, grant_d;
   logic [NUM_S-1:0] rsel_q;

   logic [IW-1:0]    cand_c;
   logic [IW-1:0]    pick_c;
   logic             found_other_c;
   logic             found_any_c;
   logic             keep_c;
   logic             hit_c;

`ifdef BUS_TIMEOUT_EN
   logic [HW-1:0]    hold_q, hold_d;
`endif

   // Circular search from last+1; last itself is tried only after everyone else
   always_comb begin
      found_other_c = 1'b0;
      pick_c        = last_q;
      cand_c        = '0;
      for (int unsigned i = 1; i < NUM_M; i++) begin
         cand_c = IW'((32'(last_q) + i) % NUM_M);
         if (!found_other_c && M_req[cand_c]) begin
            found_other_c = 1'b1;
            pick_c        = cand_c;
         end
      end
      found_any_c = found_other_c | M_req[last_q];
   end

   // Ownership next state; last always tracks the current owner
   always_comb begin
      owner_valid_d = owner_valid_q;
      owner_d       = owner_q;
      last_d        = last_q;
      keep_c        = owner_valid_q & M_req[owner_q];
`ifdef BUS_TIMEOUT_EN
      // Preempt once the owner has used its full slot and someone else waits
      if (hold_q == HW'(MAX_HOLD - 1) && found_other_c) begin
         keep_c = 1'b0;
      end
`endif
      if (!keep_c) begin
         if (found_any_c) begin
            owner_valid_d = 1'b1;
            owner_d       = pick_c;
            last_d        = pick_c;
         end else begin
            owner_valid_d = 1'b0;
         end
      end
      grant_d = owner_valid_d ? (NUM_M'(1) << owner_d) : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_valid_q <= 1'b0;
         owner_q       <= '0;
         last_q        <= IW'(NUM_M - 1);
         grant_q       <= '0;
         rsel_q        <= '0;
      end else begin
         owner_valid_q <= owner_valid_d;
         owner_q       <= owner_d;
         last_q        <= last_d;
         grant_q       <= grant_d;
         rsel_q        <= S_sel;
      end
   end

`ifdef BUS_TIMEOUT_EN
   // Counts retained cycles, saturating at the preemption threshold
   always_comb begin
      hold_d = '0;
      if (keep_c) begin
         hold_d = (hold_q == HW'(MAX_HOLD - 1)) ? hold_q : hold_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`endif

   assign M_grant = grant_q;

   // Forward path from the current owner
   always_comb begin
      S_addr = '0;
      S_wr   = 1'b0;
      S_din  = '0;
      if (owner_valid_q) begin
         S_addr = M_addr[owner_q*AW +: AW];
         S_wr   = M_wr[owner_q];
         S_din  = M_dout[owner_q*DW +: DW];
      end
   end

   // Window decode; lowest matching index wins so the select stays one-hot
   always_comb begin
      S_sel = '0;
      hit_c = 1'b0;
      for (int unsigned k = 0; k < NUM_S; k++) begin
         if (!hit_c && owner_valid_q &&
             ((S_addr & S_MASK[k*AW +: AW]) == S_BASE[k*AW +: AW])) begin
            S_sel[k] = 1'b1;
            hit_c    = 1'b1;
         end
      end
   end

   // Read return uses the select registered on the previous edge
   always_comb begin
      M_din = '0;
      for (int unsigned k = 0; k < NUM_S; k++) begin
         if (rsel_q[k]) begin
            M_din = S_dout[k*DW +: DW];
         end
      end
   end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Testbench for bus_rr_arbiter (2 masters, 2 default slave windows).
// Inputs change 1 time unit after the rising edge, outputs are sampled on
// the falling edge. Read data and grant expectations go through queues.
module tb_bus_rr_arbiter;

   localparam logic [31:0] D0 = 32'hDEADBEEF;
   localparam logic [31:0] D1 = 32'hCAFEF00D;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  M_req;
   logic [1:0]  M_wr;
   logic [15:0] M_addr;
   logic [63:0] M_dout;
   logic [1:0]  M_grant;
   logic [31:0] M_din;
   logic [1:0]  S_sel;
   logic [7:0]  S_addr;
   logic        S_wr;
   logic [31:0] S_din;
   logic [63:0] S_dout;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   logic [1:0]  gnt_q[$];

   assign S_dout = {D1, D0};

   always #5 clk = ~clk;

   bus_rr_arbiter #(
      .NUM_M(2), .NUM_S(2), .AW(8), .DW(32), .MAX_HOLD(4)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .M_req(M_req), .M_wr(M_wr), .M_addr(M_addr), .M_dout(M_dout),
      .M_grant(M_grant), .M_din(M_din),
      .S_sel(S_sel), .S_addr(S_addr), .S_wr(S_wr), .S_din(S_din),
      .S_dout(S_dout)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Reference decode of the default windows: 0x00-0x1F and 0x30-0x3F
   function automatic logic [1:0] exp_sel(input logic [7:0] a);
      if (a <= 8'h1F) return 2'b01;
      else if (a >= 8'h30 && a <= 8'h3F) return 2'b10;
      else return 2'b00;
   endfunction

   function automatic logic [31:0] exp_data(input logic [7:0] a);
      case (exp_sel(a))
         2'b01:   return D0;
         2'b10:   return D1;
         default: return 32'h0;
      endcase
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      M_req   = 2'b11;
      M_wr    = 2'b11;
      M_addr  = 16'h3405;
      M_dout  = {2{32'hFFFF_FFFF}};
      step(); step(); mid();
      n_checks++; if (M_grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b want 00", M_grant); end
      n_checks++; if (S_sel !== 2'b00) begin n_fail++; $display("FAIL rst_sel: got %b want 00", S_sel); end
      n_checks++; if (S_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr: got %h want 00", S_addr); end
      n_checks++; if (S_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr: got %b want 0", S_wr); end
      n_checks++; if (S_din !== 32'h0) begin n_fail++; $display("FAIL rst_din: got %h want 0", S_din); end
      n_checks++; if (M_din !== 32'h0) begin n_fail++; $display("FAIL rst_mdin: got %h want 0", M_din); end
      step();
      M_req = '0; M_wr = '0; M_addr = '0; M_dout = '0;
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         mid();
         n_checks++;
         if ({M_grant, S_sel, S_addr, S_wr, S_din, M_din} !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: grant=%b sel=%b addr=%h wr=%b din=%h mdin=%h want all 0",
                     M_grant, S_sel, S_addr, S_wr, S_din, M_din);
         end
         step();
      end
   endtask

   task automatic test_single_read();
      logic [7:0]  addrs [6];
      logic [31:0] want;
      addrs = '{8'h05, 8'h34, 8'h25, 8'h1F, 8'h3F, 8'h20};
      M_req  = 2'b01;
      M_wr   = 2'b00;
      M_addr = {8'h33, addrs[0]};
      M_dout = {32'h5555_5555, 32'h0};
      exp_q.push_back(32'h0);
      mid();
      n_checks++; if (M_grant !== 2'b00) begin n_fail++; $display("FAIL req_cycle_grant: got %b want 00", M_grant); end
      step();
      for (int i = 0; i < 6; i++) begin
         M_addr[7:0] = addrs[i];
         mid();
         n_checks++; if (M_grant !== 2'b01) begin n_fail++; $display("FAIL rd_grant[%0d]: got %b want 01", i, M_grant); end
         n_checks++; if (S_addr !== addrs[i]) begin n_fail++; $display("FAIL rd_addr[%0d]: got %h want %h", i, S_addr, addrs[i]); end
         n_checks++; if (S_sel !== exp_sel(addrs[i])) begin n_fail++; $display("FAIL rd_sel[%0d]: got %b want %b", i, S_sel, exp_sel(addrs[i])); end
         want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
         n_checks++; if (M_din !== want) begin n_fail++; $display("FAIL rd_data[%0d]: got %h want %h", i, M_din, want); end
         exp_q.push_back(exp_data(addrs[i]));
         step();
      end
      // Owner drops req but still drives this cycle
      M_req = 2'b00;
      mid();
      n_checks++; if (M_grant !== 2'b01) begin n_fail++; $display("FAIL release_cycle_grant: got %b want 01", M_grant); end
      want = exp_q.pop_front();
      n_checks++; if (M_din !== want) begin n_fail++; $display("FAIL rd_data_last: got %h want %h", M_din, want); end
      exp_q.push_back(exp_data(addrs[5]));
      step();
      mid();
      n_checks++; if (M_grant !== 2'b00) begin n_fail++; $display("FAIL released_grant: got %b want 00", M_grant); end
      want = exp_q.pop_front();
      n_checks++; if (M_din !== want) begin n_fail++; $display("FAIL rd_data_after: got %h want %h", M_din, want); end
      n_checks++; if (S_addr !== 8'h00) begin n_fail++; $display("FAIL noowner_addr: got %h want 00", S_addr); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rd_sb_leftover: got %0d want 0", exp_q.size()); end
      step();
   endtask

   task automatic test_write();
      M_req  = 2'b10;
      M_wr   = 2'b10;
      M_addr = {8'h31, 8'h07};
      M_dout = {32'h1234_5678, 32'hA5A5_A5A5};
      mid();
      n_checks++; if (S_wr !== 1'b0) begin n_fail++; $display("FAIL wr_before_grant: got %b want 0", S_wr); end
      step();
      mid();
      n_checks++; if (M_grant !== 2'b10) begin n_fail++; $display("FAIL wr_grant: got %b want 10", M_grant); end
      n_checks++; if (S_wr !== 1'b1) begin n_fail++; $display("FAIL wr_strobe: got %b want 1", S_wr); end
      n_checks++; if (S_addr !== 8'h31) begin n_fail++; $display("FAIL wr_addr: got %h want 31", S_addr); end
      n_checks++; if (S_din !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_data: got %h want 12345678", S_din); end
      n_checks++; if (S_sel !== 2'b10) begin n_fail++; $display("FAIL wr_sel: got %b want 10", S_sel); end
      step();
      M_wr   = 2'b00;
      M_addr = {8'h08, 8'h07};
      M_dout = {32'h0BAD_F00D, 32'hA5A5_A5A5};
      mid();
      n_checks++; if (S_sel !== 2'b01) begin n_fail++; $display("FAIL m1_sel_s0: got %b want 01", S_sel); end
      n_checks++; if (S_wr !== 1'b0) begin n_fail++; $display("FAIL m1_rd_strobe: got %b want 0", S_wr); end
      n_checks++; if (S_din !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL m1_din: got %h want 0badf00d", S_din); end
      n_checks++; if (M_din !== D1) begin n_fail++; $display("FAIL m1_mdin: got %h want %h", M_din, D1); end
      step();
      M_req = 2'b00;
      step();
      mid();
      n_checks++; if (M_grant !== 2'b00) begin n_fail++; $display("FAIL wr_release: got %b want 00", M_grant); end
      step();
   endtask

   task automatic test_round_robin();
      logic [1:0] want;
      reset_n = 1'b0;
      M_req = '0; M_wr = '0; M_addr = {8'h35, 8'h10}; M_dout = '0;
      step();
      reset_n = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         // Each master drops req for one cycle right after its transfer
         if (k == 0)        M_req = 2'b11;
         else if (k == 10)  M_req = 2'b00;
         else if (k == 9)   M_req = 2'b00;
         else if (k % 2)    M_req = 2'b10;
         else               M_req = 2'b01;
         if (k < 10) gnt_q.push_back((k + 1 == 10) ? 2'b00 : (((k + 1) % 2) ? 2'b01 : 2'b10));
         mid();
         if (k > 0) begin
            want = gnt_q.pop_front();
            n_checks++; if (M_grant !== want) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, M_grant, want); end
         end
         step();
      end
   endtask

   task automatic test_handover_reset();
      M_req  = 2'b01;
      M_wr   = 2'b00;
      M_addr = {8'h32, 8'h05};
      M_dout = {32'h1111_1111, 32'h2222_2222};
      step();
      M_req = 2'b11;
      mid();
      n_checks++; if (M_grant !== 2'b01) begin n_fail++; $display("FAIL ho_first: got %b want 01", M_grant); end
      step();
      M_req = 2'b10;
      mid();
      n_checks++; if (M_grant !== 2'b01) begin n_fail++; $display("FAIL ho_drop_cycle: got %b want 01", M_grant); end
      step();
      M_wr = 2'b10;
      mid();
      n_checks++; if (M_grant !== 2'b10) begin n_fail++; $display("FAIL ho_direct: got %b want 10", M_grant); end
      n_checks++; if (S_sel !== 2'b10) begin n_fail++; $display("FAIL ho_sel: got %b want 10", S_sel); end
      step();
      M_req = 2'b01;
      step();
      M_req = 2'b11;
      M_wr  = 2'b01;
      mid();
      n_checks++; if (M_grant !== 2'b01) begin n_fail++; $display("FAIL ho_back: got %b want 01", M_grant); end
      n_checks++; if (S_din !== 32'h2222_2222) begin n_fail++; $display("FAIL ho_din: got %h want 22222222", S_din); end
      step();
      // Asynchronous reset in the middle of master 0's ownership
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({M_grant, S_sel, S_addr, S_wr, S_din, M_din} !== '0) begin
         n_fail++;
         $display("FAIL midop_reset: grant=%b sel=%b addr=%h wr=%b din=%h mdin=%h want all 0",
                  M_grant, S_sel, S_addr, S_wr, S_din, M_din);
      end
      step();
      reset_n = 1'b1;
      mid();
      n_checks++; if (M_grant !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle: got %b want 00", M_grant); end
      step();
      mid();
      n_checks++; if (M_grant !== 2'b01) begin n_fail++; $display("FAIL post_reset_prio: got %b want 01", M_grant); end
      M_req = 2'b00;
      M_wr  = 2'b00;
      step();
      step();
   endtask

   task automatic test_timeout();
      logic [1:0] want;
      int         n;
      M_req = 2'b01;
      step();
      M_req = 2'b11;
`ifdef BUS_TIMEOUT_EN
      n = 12;
      for (int j = 0; j < n; j++) gnt_q.push_back(((j / 4) % 2) ? 2'b10 : 2'b01);
`else
      n = 22;
      for (int j = 0; j < n; j++) gnt_q.push_back(2'b01);
`endif
      for (int j = 0; j < n; j++) begin
         mid();
         want = gnt_q.pop_front();
         n_checks++; if (M_grant !== want) begin n_fail++; $display("FAIL hold_grant[%0d]: got %b want %b", j, M_grant, want); end
         step();
      end
      M_req = 2'b00;
      step();
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_round_robin();
      test_handover_reset();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Parametrised shared-bus interconnect for multiple masters and multiple slaves. It uses registered round-robin arbitration and per-slave address windows, and returns read data through a registered slave select. It sits between the processor, DMA and test masters and the memory/peripheral slaves. It is the multi-master successor of the single-master two-slave bus.

## Interface
- NUM_M, 2: number of masters (2..8)
- NUM_S, 2: number of slaves (1..8)
- AW, 8: address width
- DW, 32: data width
- S_BASE, {8'h30, 8'h00}: packed NUM_S×AW slave base addresses; slave i occupies bits [i*AW +: AW]
- S_MASK, {8'hF0, 8'hE0}: packed NUM_S×AW compare masks; slave i matches when (addr & mask_i) == base_i
- MAX_HOLD, 16: ownership cycle limit (used only with BUS_TIMEOUT_EN)
- clk  in  1  bus clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- M_req  in  NUM_M  per-master bus request
- M_wr  in  NUM_M  per-master write strobe
- M_addr  in  NUM_M×AW  packed master addresses
- M_dout  in  NUM_M×DW  packed master write data
- M_grant  out  NUM_M  one-hot grant, registered
- M_din  out  DW  read data, broadcast to all masters
- S_sel  out  NUM_S  one-hot slave select
- S_addr  out  AW  slave address
- S_wr  out  1  slave write strobe
- S_din  out  DW  slave write data
- S_dout  in  NUM_S×DW  packed slave read data

## Operation
- State: owner_valid, owner index, last-owner pointer, registered select rsel[NUM_S], hold counter (timeout build only).
- Arbitration runs on every rising edge:
  - If there is no owner, or the owner's M_req is low, grant the first requesting master searching circularly from last+1.
  - When a grant is issued, last is set to the new owner.
  - If no master is requesting, owner_valid goes to 0.
  - While the owner keeps M_req high, the grant is held.
- Handover: the owner drops req and another master requests at the same edge → grant moves directly to that master, with no idle cycle.
- Forward path is combinational from the owner's signals:
  - S_addr, S_wr and S_din follow the owner's M_addr, M_wr and M_dout.
  - With no owner, all three are 0.
- Decode:
  - S_sel[i] = owner_valid & ((S_addr & mask_i) == base_i).
  - Overlapping windows: the lowest index wins, so S_sel stays one-hot.
  - Address miss → S_sel = 0.
  - Defaults map slave 0 to 0x00–0x1F and slave 1 to 0x30–0x3F.
- Read return:
  - rsel <= S_sel on every edge.
  - M_din = S_dout of slave k when rsel[k] is set, else 0.
- Arithmetic: the index and pointer are $clog2(NUM_M) bits wide; the circular search wraps modulo NUM_M.

## Timing
- Reset values: M_grant=0, owner_valid=0, last=NUM_M-1 (master 0 has first priority), rsel=0, hold counter=0. As a result S_sel=0, S_addr=0, S_wr=0, S_din=0, M_din=0.
- Request → grant: M_req rises in cycle t → M_grant is set from cycle t+1.
- Grant → slave: S_* outputs are valid in the same cycle as M_grant.
- Read latency: the address is presented in cycle t → M_din carries that slave's data in cycle t+1.
- Write: the slave samples S_wr and S_din at the edge ending any granted cycle.
- Release: the owner drops M_req in cycle t → M_grant falls (or moves to another master) from cycle t+1. The owner is still driving the bus during cycle t.
- Simultaneous requests: the requester closest after last, circularly, wins. No master waits more than NUM_M-1 ownerships.
- Reset asserted mid-transfer clears everything immediately. After reset deasserts, arbitration restarts from master 0 priority.

## Configuration
- BUS_TIMEOUT_EN defined:
  - The hold counter increments each cycle the same owner is retained, and resets to 0 on every grant change.
  - When the counter reaches MAX_HOLD-1 while any other master is requesting, the next edge forces the grant to the next requester, even though the owner's M_req is still high.
  - The preempted master re-enters round-robin normally.
- BUS_TIMEOUT_EN undefined: no counter is built, and the owner keeps the grant indefinitely while its M_req stays high.

## Test plan
- Reset then idle: hold reset_n=0 → every output is 0. Release reset with all M_req=0 → outputs stay 0.
- Single master read: M_req[0]=1, addr 0x05 → M_grant=2'b01 next cycle, S_sel=2'b01. One cycle later M_din=S_dout[0] (0xDEADBEEF). Repeat with addr 0x34 → M_din=S_dout[1]. Addr 0x25 → S_sel=0 and M_din=0.
- Write forwarding: master 1 granted, M_wr=1, addr 0x31, data 0x12345678 → S_wr=1, S_addr=0x31, S_din=0x12345678, S_sel=2'b10.
- Round-robin: both masters request continuously and each drops req for one cycle after every transfer → grants alternate 0,1,0,1, with master 0 first after reset.
- Handover and mid-op reset: master 0 drops req while master 1 requests → M_grant goes 01→10 with no idle cycle. Then assert reset_n=0 mid-grant → M_grant=0 and S_* =0 immediately.
- Timeout (BUS_TIMEOUT_EN, MAX_HOLD=4): master 0 holds req and master 1 requests → after 4 owned cycles the grant moves to master 1. Without the macro, master 0 keeps the grant for 20+ cycles.
